// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared control-vector layout, hazard FSM encoding and counter helpers
// Purpose: one definition of the decode control bundles, the ID/EX hazard FSM
//          states and the event-counter width, shared by decode, the ID/EX
//          register and downstream stages.
// Ports:   none (package).
package id_ex_stage_pkg;

  // Control vector widths
  localparam int CTRL_E_W = 5;
  localparam int CTRL_M_W = 3;
  localparam int CTRL_W_W = 2;

  // control_E = {ALUSrc, RegDst, JRop, ALUOp[1:0]}
  localparam int E_ALUSRC   = 4;
  localparam int E_REGDST   = 3;
  localparam int E_JROP     = 2;
  localparam int E_ALUOP_HI = 1;
  localparam int E_ALUOP_LO = 0;

  // control_M = {Branch, MemWrite, MemRead}
  localparam int M_BRANCH   = 2;
  localparam int M_MEMWRITE = 1;
  localparam int M_MEMREAD  = 0;

  // control_W = {MemtoReg, RegWrite}
  localparam int W_MEMTOREG = 1;
  localparam int W_REGWRITE = 0;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Hazard FSM: RUN is the reset/default state
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_t;

  // Event counters
  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard compare
// Purpose: flags a load in EX whose destination (ex_rt, nonzero) is a source
//          of the instruction currently in ID.
// Ports:   ex_mem_read - MemRead bit of the registered EX control
//          ex_rt       - destination register of the EX load
//          rs_id/rt_id - source registers of the ID instruction
//          hazard      - raw compare result (no FSM gating)
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             hazard
);

  // $zero is never a real dependency, so a load targeting r0 never stalls.
  assign hazard = ex_mem_read && (ex_rt != '0) && ((ex_rt == rs_id) || (ex_rt == rt_id));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush bubbles
// Purpose: registers decode outputs into EX, inserts a bubble on a load-use
//          hazard or a redirect flush, and counts stall and flush events.
// Ports:   clk, rst_n (async active-low)
//          control_E/M/W, rs_data, rt_data, imm_ext, pc_plus4, rs_id, rt_id,
//          rd_id, flush - ID-stage inputs
//          ex_* - registered EX-stage copies
//          stall - combinational hold request for PC and IF/ID
//          stall_cnt, flush_cnt - saturating event counters
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CTRL_E_W-1:0] control_E,
  input  logic [CTRL_M_W-1:0] control_M,
  input  logic [CTRL_W_W-1:0] control_W,
  input  logic [DATA_W-1:0]   rs_data,
  input  logic [DATA_W-1:0]   rt_data,
  input  logic [DATA_W-1:0]   imm_ext,
  input  logic [DATA_W-1:0]   pc_plus4,
  input  logic [REG_W-1:0]    rs_id,
  input  logic [REG_W-1:0]    rt_id,
  input  logic [REG_W-1:0]    rd_id,
  input  logic                flush,
  output logic [CTRL_E_W-1:0] ex_control_E,
  output logic [CTRL_M_W-1:0] ex_control_M,
  output logic [CTRL_W_W-1:0] ex_control_W,
  output logic [DATA_W-1:0]   ex_rs_data,
  output logic [DATA_W-1:0]   ex_rt_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]   ex_pc_plus4,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_rd,
  output logic                stall,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  hz_state_t state;
  hz_state_t state_next;
  logic      hazard;
  logic      bubble;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_control_M[M_MEMREAD]),
    .ex_rt       (ex_rt),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .hazard      (hazard)
  );

  // The STALL gate is belt-and-braces: the bubble already clears MemRead,
  // but gating on state guarantees a load-use stall lasts one cycle.
  assign stall  = rst_n && (state == ST_RUN) && hazard;
  assign bubble = flush || stall;

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (stall && !flush) state_next = ST_STALL;
      ST_STALL: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Pipeline register: a bubble zeroes everything, not just the controls,
  // so a squashed slot is fully deterministic downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_control_E <= '0;
      ex_control_M <= '0;
      ex_control_W <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_pc_plus4  <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
    end else if (bubble) begin
      ex_control_E <= '0;
      ex_control_M <= '0;
      ex_control_W <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_pc_plus4  <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
    end else begin
      ex_control_E <= control_E;
      ex_control_M <= control_M;
      ex_control_W <= control_W;
      ex_rs_data   <= rs_data;
      ex_rt_data   <= rt_data;
      ex_imm       <= imm_ext;
      ex_pc_plus4  <= pc_plus4;
      ex_rs        <= rs_id;
      ex_rt        <= rt_id;
      ex_rd        <= rd_id;
    end
  end

  // A stall coinciding with a flush is attributed to the flush only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      flush_cnt <= sat_inc(flush_cnt);
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  control_E;
  logic [2:0]  control_M;
  logic [1:0]  control_W;
  logic [31:0] rs_data, rt_data, imm_ext, pc_plus4;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic        flush;
  logic [4:0]  ex_control_E;
  logic [2:0]  ex_control_M;
  logic [1:0]  ex_control_W;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .control_E(control_E), .control_M(control_M), .control_W(control_W),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .pc_plus4(pc_plus4),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .flush(flush),
    .ex_control_E(ex_control_E), .ex_control_M(ex_control_M), .ex_control_W(ex_control_W),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: what EX should hold, plus event tallies.
  logic [4:0]  m_E;
  logic [2:0]  m_M;
  logic [1:0]  m_W;
  logic [31:0] m_rs_data, m_rt_data, m_imm, m_pc;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_scnt, m_fcnt;
  bit          m_after_stall;
  bit          m_s;

  // A load in EX writing a nonzero register that ID reads forces a stall,
  // except in the cycle right after a stall (its bubble is in EX).
  function automatic bit model_stall();
    if (!rst_n || m_after_stall) return 1'b0;
    return m_M[0] && (m_rt != 5'd0) && ((m_rt == rs_id) || (m_rt == rt_id));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_E = 0; m_M = 0; m_W = 0;
      m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_pc = 0;
      m_rs = 0; m_rt = 0; m_rd = 0;
      m_scnt = 0; m_fcnt = 0; m_after_stall = 0;
    end else begin
      m_s = model_stall();
      if (flush || m_s) begin
        m_E = 0; m_M = 0; m_W = 0;
        m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_pc = 0;
        m_rs = 0; m_rt = 0; m_rd = 0;
      end else begin
        m_E = control_E; m_M = control_M; m_W = control_W;
        m_rs_data = rs_data; m_rt_data = rt_data; m_imm = imm_ext; m_pc = pc_plus4;
        m_rs = rs_id; m_rt = rt_id; m_rd = rd_id;
      end
      if (flush) m_fcnt = (m_fcnt >= 65535) ? 65535 : m_fcnt + 1;
      else if (m_s) m_scnt = (m_scnt >= 65535) ? 65535 : m_scnt + 1;
      m_after_stall = m_s && !flush;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      check("ex_control_E", 32'(ex_control_E), 32'(m_E));
      check("ex_control_M", 32'(ex_control_M), 32'(m_M));
      check("ex_control_W", 32'(ex_control_W), 32'(m_W));
      check("ex_rs_data", ex_rs_data, m_rs_data);
      check("ex_rt_data", ex_rt_data, m_rt_data);
      check("ex_imm", ex_imm, m_imm);
      check("ex_pc_plus4", ex_pc_plus4, m_pc);
      check("ex_rs", 32'(ex_rs), 32'(m_rs));
      check("ex_rt", 32'(ex_rt), 32'(m_rt));
      check("ex_rd", 32'(ex_rd), 32'(m_rd));
      check("stall", 32'(stall), 32'(model_stall()));
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      check("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    end
  end

  task automatic set_id(input logic [4:0] e, input logic [2:0] m, input logic [1:0] w,
                        input logic [31:0] rsd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    control_E = e; control_M = m; control_W = w;
    rs_data = rsd; rt_data = rsd ^ 32'hA5A5_0000; imm_ext = {27'd0, rd}; pc_plus4 = rsd + 32'd4;
    rs_id = rs; rt_id = rt; rd_id = rd;
  endtask

  initial begin
    flush = 1'b0;
    set_id(5'd0, 3'd0, 2'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    #3;
    check("rst_init_W", 32'(ex_control_W), 32'h0);
    check("rst_init_stall", 32'(stall), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Pass-through
    @(negedge clk);
    set_id(5'b01010, 3'b000, 2'b11, 32'h12345678, 5'd1, 5'd2, 5'd3);
    @(negedge clk); #3;
    check("pt_E", 32'(ex_control_E), 32'h0A);
    check("pt_W", 32'(ex_control_W), 32'h3);
    check("pt_rs_data", ex_rs_data, 32'h12345678);
    check("pt_stall", 32'(stall), 32'h0);

    // Load-use on rs
    set_id(5'b00000, 3'b001, 2'b11, 32'h0000_1000, 5'd4, 5'd8, 5'd0);
    @(negedge clk);
    set_id(5'b00011, 3'b000, 2'b01, 32'h0000_2000, 5'd8, 5'd3, 5'd5);
    #3 check("lu_stall", 32'(stall), 32'h1);
    @(negedge clk); #3;
    check("lu_bubble_E", 32'(ex_control_E), 32'h0);
    check("lu_bubble_M", 32'(ex_control_M), 32'h0);
    check("lu_bubble_W", 32'(ex_control_W), 32'h0);
    check("lu_stall_clr", 32'(stall), 32'h0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'h1);

    // No false hazard: load to r0, then load to r9 against r8/r10
    @(negedge clk);
    set_id(5'd0, 3'b001, 2'd0, 32'h3, 5'd1, 5'd0, 5'd0);
    @(negedge clk);
    set_id(5'd0, 3'b000, 2'd0, 32'h4, 5'd0, 5'd2, 5'd0);
    #3 check("fh_zero", 32'(stall), 32'h0);
    @(negedge clk);
    set_id(5'd0, 3'b001, 2'd0, 32'h5, 5'd1, 5'd9, 5'd0);
    @(negedge clk);
    set_id(5'd0, 3'b000, 2'd0, 32'h6, 5'd8, 5'd10, 5'd0);
    #3 check("fh_diff", 32'(stall), 32'h0);

    // Asynchronous reset mid-cycle with RegWrite/MemtoReg live in EX
    @(negedge clk);
    set_id(5'd0, 3'b000, 2'b11, 32'h7, 5'd1, 5'd2, 5'd0);
    @(posedge clk); #2;
    check("rr_pre_W", 32'(ex_control_W), 32'h3);
    rst_n = 1'b0;
    #1;
    check("rr_W", 32'(ex_control_W), 32'h0);
    check("rr_rs_data", ex_rs_data, 32'h0);
    check("rr_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rr_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hazard and flush in the same cycle: flush wins
    @(negedge clk);
    set_id(5'd0, 3'b001, 2'd0, 32'h8, 5'd1, 5'd8, 5'd0);
    @(negedge clk);
    set_id(5'b10000, 3'b000, 2'b01, 32'h9, 5'd8, 5'd2, 5'd4);
    flush = 1'b1;
    #3 check("pr_stall", 32'(stall), 32'h1);
    @(negedge clk);
    flush = 1'b0;
    #3;
    check("pr_M", 32'(ex_control_M), 32'h0);
    check("pr_W", 32'(ex_control_W), 32'h0);
    check("pr_flush_cnt", 32'(flush_cnt), 32'h1);
    check("pr_stall_cnt", 32'(stall_cnt), 32'h0);

    // Saturation of stall_cnt from a preloaded value
    @(negedge clk);
    force dut.stall_cnt = 16'hFFFE;
    m_scnt = 16'hFFFE;
    #1 release dut.stall_cnt;
    repeat (2) begin
      @(negedge clk);
      set_id(5'd0, 3'b001, 2'd0, 32'hA, 5'd1, 5'd8, 5'd0);
      @(negedge clk);
      set_id(5'd0, 3'b000, 2'd0, 32'hB, 5'd8, 5'd2, 5'd0);
    end
    @(negedge clk); #3;
    check("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);

    // Randomized traffic with small register space to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      control_E = 5'($urandom);
      control_M = {2'($urandom), 1'($urandom_range(0, 1))};
      control_W = 2'($urandom);
      rs_data   = $urandom;
      rt_data   = $urandom;
      imm_ext   = $urandom;
      pc_plus4  = $urandom;
      rs_id     = 5'($urandom_range(0, 3));
      rt_id     = 5'($urandom_range(0, 3));
      rd_id     = 5'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      if ((i % 500) == 250) begin
        #4 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: control_E  in  5  {ALUSrc,RegDst,JRop,ALUOp[1:0]} from decode control; control_M  in  3  {Branch,MemWrite,MemRead}; control_W  in  2  {MemtoReg,RegWrite}.
REQ-003 SHALL have ports: rs_data, rt_data  in  32 each  register-file read data; imm_ext  in  32  sign-extended immediate; pc_plus4  in  32; rs_id, rt_id, rd_id  in  5 each  ID-stage register addresses.
REQ-004 SHALL have port: flush  in  1  taken branch/jump/JR redirect; squashes the ID instruction.
REQ-005 SHALL have ports: ex_control_E  out  5; ex_control_M  out  3; ex_control_W  out  2; ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4  out  32 each; ex_rs, ex_rt, ex_rd  out  5 each.
REQ-006 SHALL have ports: stall  out  1  combinational, holds PC and IF/ID; stall_cnt, flush_cnt  out  16 each  saturating counters.

Function
REQ-007 SHALL register all ID inputs into EX outputs on each rising clk when neither bubble nor flush applies (latency 1 cycle).
REQ-008 SHALL assert stall combinationally when ex_control_M[0]=1 (load in EX), ex_rt!=0, and ex_rt equals rs_id or rt_id.
REQ-009 SHALL, on a cycle where stall=1, load a bubble: ex_control_E/M/W all zero; data and address outputs don't-care but SHALL be loaded with zero.
REQ-010 SHALL, on a cycle where flush=1, load a bubble identically to REQ-009, regardless of stall (flush has priority).
REQ-011 SHALL run a two-state FSM: RUN (default) -> STALL when stall=1 and flush=0; STALL -> RUN unconditionally next cycle.
REQ-012 SHALL never assert stall in state STALL (the bubble in EX carries MemRead=0), bounding any load-use stall to exactly one cycle.
REQ-013 SHALL treat an all-zero instruction's control (ALUOp=2'b11, all else 0) as ordinary data: registered unchanged, no special handling.
REQ-014 SHALL pass x-valued control from unimplemented opcodes unchanged; stall evaluation SHALL use only registered ex_control_M[0].
REQ-015 SHALL increment stall_cnt once per cycle in which stall=1 and flush=0, saturating at 16'hFFFF.
REQ-016 SHALL increment flush_cnt once per cycle in which flush=1, saturating at 16'hFFFF.
REQ-017 SHALL count simultaneous stall and flush only in flush_cnt.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear all EX outputs to zero, both counters to zero, and FSM to RUN.
REQ-019 SHALL drive stall=0 while rst_n is low.
REQ-020 SHALL resume registering on the first rising clk after rst_n deasserts; reset mid-stall SHALL discard the pending bubble and return to RUN.

Structure
REQ-021 SHALL place control-vector widths (5/3/2), bit indices (ALUSrc=4, RegDst=3, JRop=2, ALUOp=1:0, Branch=2, MemWrite=1, MemRead=0, MemtoReg=1, RegWrite=0), FSM state encoding and counter width in a shared package used by decode and downstream stages.
REQ-022 SHALL instantiate one sub-module, load_use_detect, containing only the combinational REQ-008 compare.
REQ-023 SHALL contain no other sub-modules; counters and FSM are local.

Verification
REQ-024 Reset: rst_n=0 mid-cycle with ex_control_W=2'b11 -> all outputs 0 immediately, counters 0, stall 0.
REQ-025 Pass-through: control_E=5'b01010, control_W=2'b11, rs_data=32'h12345678 -> same values on EX outputs one clk later, stall 0.
REQ-026 Load-use: cycle N EX holds LW (control_M=3'b001, ex_rt=5'd8), ID rs_id=8 -> stall=1 in N; EX controls zero at N+1; stall=0 at N+1; stall_cnt=1.
REQ-027 No false hazard: LW with ex_rt=0 and rs_id=0 -> stall=0; LW ex_rt=9, rs_id=8, rt_id=10 -> stall=0.
REQ-028 Priority: load-use hazard and flush=1 same cycle -> bubble loaded, FSM stays RUN, flush_cnt=1, stall_cnt=0.
REQ-029 Saturation: preload stall_cnt to 16'hFFFE, two further stall cycles -> stall_cnt=16'hFFFF, no wrap.
